// File: rtl/ones_pkg.sv
// Shared types and defaults for the ones generator (thermometer-code builder).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ones_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } gen_state_t;

endpackage

// File: rtl/ones_generator_datapath.sv
// Datapath for the ones generator: holds the word, remaining-ones count and saturation flag.
// Latency: one register update per clock; load on load_i, one shift per clock on shift_i.
// Backpressure: none; the controller sequences load_i/shift_i.
//
// Ports:
//   clock, reset_n  : clock and asynchronous active-low reset
//   load_i          : latch clamped count, clear word, update sat
//   shift_i         : shift a one in at the LSB while rem is non-zero
//   count_in_i      : requested number of ones
//   word_o, sat_o   : generated word and saturation flag
//   rem_le1_o       : remaining count is 0 or 1 (last shift happens this edge)
module ones_generator_datapath
  import ones_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [CW-1:0]    count_in_i,
  output logic [WIDTH-1:0] word_o,
  output logic             sat_o,
  output logic             rem_le1_o
);

  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             sat_q, sat_d;
  logic             over_w;
  logic [CW-1:0]    clamp_w;

  // WIDTH always fits in CW bits because CW covers WIDTH+1 values.
  assign over_w  = (count_in_i > CW'(WIDTH));
  assign clamp_w = over_w ? CW'(WIDTH) : count_in_i;

  always_comb begin
    word_d = word_q;
    rem_d  = rem_q;
    sat_d  = sat_q;
    if (load_i) begin
      word_d = '0;
      rem_d  = clamp_w;
      sat_d  = over_w;
    end else if (shift_i && (rem_q != '0)) begin
      // Only ones are shifted in; the cleared upper bits provide the zeros.
      word_d = {word_q[WIDTH-2:0], 1'b1};
      rem_d  = rem_q - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      rem_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      rem_q  <= rem_d;
      sat_q  <= sat_d;
    end
  end

  assign word_o    = word_q;
  assign sat_o     = sat_q;
  assign rem_le1_o = (rem_q <= CW'(1));

endmodule

// File: rtl/ones_generator.sv
// Builds a WIDTH-bit thermometer word with min(count_in, WIDTH) ones at the LSB end.
// Latency: done rises max(N,1) edges after the edge that accepts start.
// Backpressure: start/done level handshake; start must drop in DONE before a new request.
//
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : level request, sampled in IDLE
//   count_in       : requested number of ones, latched on the accepting edge
//   word_out       : generated word (valid while done)
//   done, busy     : Moore status, high in DONE / SHIFT respectively
//   sat            : latched request exceeded WIDTH
module ones_generator
  import ones_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CW-1:0]    count_in,
  output logic [WIDTH-1:0] word_out,
  output logic             done,
  output logic             busy,
  output logic             sat
);

  gen_state_t state_q, state_d;
  logic       load_w;
  logic       shift_w;
  logic       rem_le1_w;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_w  = 1'b0;
    shift_w = 1'b0;
    done    = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load_w  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy    = 1'b1;
        shift_w = 1'b1;
        // rem<=1 means this edge performs the last (or no) shift.
        if (rem_le1_w) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  ones_generator_datapath #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_datapath (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (load_w),
    .shift_i    (shift_w),
    .count_in_i (count_in),
    .word_o     (word_out),
    .sat_o      (sat),
    .rem_le1_o  (rem_le1_w)
  );

endmodule

// File: tb/tb_ones_generator.sv
// Directed self-checking bench for ones_generator (WIDTH=8).
// Latency: n/a.
// Backpressure: n/a.
module tb_ones_generator;

  localparam int WIDTH = 8;
  localparam int CW    = 4;
  localparam int BOUND = 40;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [CW-1:0]    count_in;
  logic [WIDTH-1:0] word_out;
  logic             done;
  logic             busy;
  logic             sat;

  int pass_cnt;
  int total_cnt;
  int busy_seen;
  int overlap_seen;

  ones_generator #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .count_in (count_in),
    .word_out (word_out),
    .done     (done),
    .busy     (busy),
    .sat      (sat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (busy === 1'b1) busy_seen++;
    if (busy === 1'b1 && done === 1'b1) overlap_seen++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept a request and wait (bounded) for done; cyc counts edges after edge 0.
  task automatic run_req(input logic [CW-1:0] n, output int cyc);
    count_in = n;
    start    = 1'b1;
    tick();
    cyc = 0;
    while (done !== 1'b1 && cyc < BOUND) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release_req();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    count_in = '0;
    tick();
    tick();
    total_cnt++;
    if ({word_out, done, busy, sat} !== {8'h00, 3'b000}) begin
      $display("FAIL reset_outputs: got word=%h done=%b busy=%b sat=%b want all zero",
               word_out, done, busy, sat);
    end else pass_cnt++;
    reset_n = 1'b1;
    tick();
    total_cnt++;
    if ({done, busy} !== 2'b00) begin
      $display("FAIL reset_idle: got done=%b busy=%b want 0 0", done, busy);
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    int b0;
    count_in = 4'd3;
    start    = 1'b1;
    b0       = busy_seen;
    tick();
    total_cnt++;
    if ({busy, done} !== 2'b10) begin
      $display("FAIL basic_edge0: got busy=%b done=%b want 1 0", busy, done);
    end else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if ({busy, done, word_out} !== {2'b10, 8'h03}) begin
      $display("FAIL basic_edge2: got busy=%b done=%b word=%h want 1 0 03", busy, done, word_out);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, done, word_out, sat} !== {2'b01, 8'h07, 1'b0}) begin
      $display("FAIL basic_done: got busy=%b done=%b word=%h sat=%b want 0 1 07 0",
               busy, done, word_out, sat);
    end else pass_cnt++;
    total_cnt++;
    if (busy_seen - b0 !== 3) begin
      $display("FAIL basic_busy_cycles: got %0d want 3", busy_seen - b0);
    end else pass_cnt++;
    // start still high: DONE holds
    tick();
    tick();
    total_cnt++;
    if ({done, word_out} !== {1'b1, 8'h07}) begin
      $display("FAIL basic_done_hold: got done=%b word=%h want 1 07", done, word_out);
    end else pass_cnt++;
    release_req();
    total_cnt++;
    if ({done, busy, word_out} !== {2'b00, 8'h07}) begin
      $display("FAIL basic_idle: got done=%b busy=%b word=%h want 0 0 07", done, busy, word_out);
    end else pass_cnt++;
  endtask

  task automatic test_zero();
    int cyc;
    int b0;
    b0 = busy_seen;
    run_req(4'd0, cyc);
    total_cnt++;
    if (cyc !== 1) begin
      $display("FAIL zero_latency: got %0d edges want 1", cyc);
    end else pass_cnt++;
    total_cnt++;
    if ({word_out, sat} !== {8'h00, 1'b0} || busy_seen - b0 !== 1) begin
      $display("FAIL zero_result: got word=%h sat=%b busy_cycles=%0d want 00 0 1",
               word_out, sat, busy_seen - b0);
    end else pass_cnt++;
    release_req();
  endtask

  task automatic test_full();
    int cyc;
    run_req(4'd8, cyc);
    total_cnt++;
    if (cyc !== 8 || word_out !== 8'hFF || sat !== 1'b0) begin
      $display("FAIL full_8: got edges=%0d word=%h sat=%b want 8 ff 0", cyc, word_out, sat);
    end else pass_cnt++;
    release_req();
    run_req(4'd15, cyc);
    total_cnt++;
    if (cyc !== 8 || word_out !== 8'hFF || sat !== 1'b1) begin
      $display("FAIL full_sat: got edges=%0d word=%h sat=%b want 8 ff 1", cyc, word_out, sat);
    end else pass_cnt++;
    release_req();
    tick();
    total_cnt++;
    if ({sat, word_out, done} !== {1'b1, 8'hFF, 1'b0}) begin
      $display("FAIL sat_hold_idle: got sat=%b word=%h done=%b want 1 ff 0", sat, word_out, done);
    end else pass_cnt++;
    run_req(4'd2, cyc);
    total_cnt++;
    if (cyc !== 2 || word_out !== 8'h03 || sat !== 1'b0) begin
      $display("FAIL sat_clear: got edges=%0d word=%h sat=%b want 2 03 0", cyc, word_out, sat);
    end else pass_cnt++;
    release_req();
  endtask

  task automatic test_input_change();
    count_in = 4'd4;
    start    = 1'b1;
    tick();
    count_in = 4'd1;
    start    = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({busy, done, word_out} !== {2'b10, 8'h03}) begin
      $display("FAIL change_midshift: got busy=%b done=%b word=%h want 1 0 03", busy, done, word_out);
    end else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if ({busy, done, word_out} !== {2'b01, 8'h0F}) begin
      $display("FAIL change_done: got busy=%b done=%b word=%h want 0 1 0f", busy, done, word_out);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, done, word_out} !== {2'b00, 8'h0F}) begin
      $display("FAIL change_idle: got busy=%b done=%b word=%h want 0 0 0f", busy, done, word_out);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    count_in = 4'd5;
    start    = 1'b1;
    tick();
    tick();
    tick();
    tick();
    total_cnt++;
    if ({busy, word_out} !== {1'b1, 8'h07}) begin
      $display("FAIL rst_mid_pre: got busy=%b word=%h want 1 07", busy, word_out);
    end else pass_cnt++;
    #2;
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    total_cnt++;
    if ({word_out, done, busy, sat} !== {8'h00, 3'b000}) begin
      $display("FAIL rst_mid_async: got word=%h done=%b busy=%b sat=%b want all zero",
               word_out, done, busy, sat);
    end else pass_cnt++;
    #1;
    reset_n = 1'b1;
    tick();
    run_req(4'd2, cyc);
    total_cnt++;
    if (cyc !== 2 || word_out !== 8'b0000_0011) begin
      $display("FAIL rst_mid_after: got edges=%0d word=%h want 2 03", cyc, word_out);
    end else pass_cnt++;
    release_req();
  endtask

  task automatic test_loopback();
    int cyc;
    int want_cyc;
    logic [WIDTH-1:0] want_word;
    for (int n = 0; n <= WIDTH; n++) begin
      run_req(CW'(n), cyc);
      want_cyc  = (n == 0) ? 1 : n;
      want_word = '0;
      for (int k = 0; k < n; k++) want_word[k] = 1'b1;
      total_cnt++;
      if ($countones(word_out) !== n || word_out !== want_word || cyc !== want_cyc) begin
        $display("FAIL loopback_n%0d: got ones=%0d word=%h edges=%0d want %0d %h %0d",
                 n, $countones(word_out), word_out, cyc, n, want_word, want_cyc);
      end else pass_cnt++;
      release_req();
    end
    total_cnt++;
    if (overlap_seen !== 0) begin
      $display("FAIL busy_done_overlap: got %0d cycles want 0", overlap_seen);
    end else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_zero();
    test_full();
    test_input_change();
    test_reset_mid();
    test_loopback();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
